// File: rtl/gf163_pkg.sv
// Shared field constants, tag type and reduction helper for the sect163r2 GF(2^163) datapath.
package gf163_pkg;

  localparam int GF_M = 163;
  // Full reduction polynomial x^163 + x^7 + x^6 + x^3 + 1, including the leading term.
  localparam logic [GF_M:0] F_POLY = (164'd1 << GF_M) | 164'hC9;

  // Tag ids are sized for the largest supported requester count so the struct is fixed-width.
  localparam int N_REQ_MAX = 8;
  localparam int ID_W      = $clog2(N_REQ_MAX);

  typedef logic [GF_M-1:0]   gf_elem_t;
  typedef logic [2*GF_M-2:0] gf_wide_t;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  // Fold a raw carry-less product back into the field, top bit first.
  function automatic gf_elem_t gf_reduce(input gf_wide_t prod);
    gf_wide_t r;
    r = prod;
    for (int i = 2*GF_M-2; i >= GF_M; i--) begin
      if (r[i]) r[i-GF_M +: GF_M+1] = r[i-GF_M +: GF_M+1] ^ F_POLY;
    end
    return r[GF_M-1:0];
  endfunction

endpackage

// File: rtl/gf2m_mult_arbiter163_mult.sv
// Pipelined GF(2^163) multiplier: split partial products, combine, reduce; LAT cycles (LAT >= 3).
module gf2m_mult163
  import gf163_pkg::*;
#(
  parameter int LAT = 3
) (
  input  logic     clk,
  input  gf_elem_t a,
  input  gf_elem_t b,
  output gf_elem_t p
);

  localparam int LO_W = 82;
  localparam int HI_W = GF_M - LO_W;

  logic [GF_M+LO_W-2:0] pp_lo, s1_lo;
  logic [GF_M+HI_W-2:0] pp_hi, s1_hi;
  gf_wide_t             s2;
  gf_elem_t             stage [LAT-2];

  // NOTE: every variable assigned in a combinational block gets a default first, or a latch is inferred.
  always_comb begin
    pp_lo = '0;
    pp_hi = '0;
    for (int i = 0; i < LO_W; i++) begin
      if (b[i]) pp_lo[i +: GF_M] = pp_lo[i +: GF_M] ^ a;
    end
    for (int i = 0; i < HI_W; i++) begin
      if (b[LO_W+i]) pp_hi[i +: GF_M] = pp_hi[i +: GF_M] ^ a;
    end
  end

  // NOTE: pure datapath registers carry no reset; validity is tracked by the caller's tag pipe.
  always_ff @(posedge clk) begin
    s1_lo    <= pp_lo;
    s1_hi    <= pp_hi;
    s2       <= gf_wide_t'(s1_lo) ^ {s1_hi, {LO_W{1'b0}}};
    stage[0] <= gf_reduce(s2);
    for (int j = 1; j < LAT-2; j++) stage[j] <= stage[j-1];
  end

  assign p = stage[LAT-3];

endmodule

// File: rtl/gf2m_mult_arbiter163.sv
// Round-robin front end sharing one pipelined GF(2^163) multiplier among N_REQ point engines.
module gf2m_mult_arbiter163
  import gf163_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MULT_LAT = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*GF_M-1:0]   req_a,
  input  logic [N_REQ*GF_M-1:0]   req_b,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [GF_M-1:0]         rsp_data,
  output logic [2:0]              inflight
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] grant_id;
  logic            grant;
  int              idx;
  gf_elem_t        op_a, op_b, mult_p;
  tag_t            tag_pipe [MULT_LAT+1];
  tag_t            retire;

  // NOTE: combinational logic uses blocking '=', clocked state uses non-blocking '<='.
  always_comb begin
    req_ready = '0;
    grant     = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!grant && req_valid[idx]) begin
        grant          = 1'b1;
        grant_id       = ID_W'(idx);
        req_ready[idx] = 1'b1;
      end
    end
    if (rst) begin
      req_ready = '0;
      grant     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant) begin
      ptr <= (grant_id == ID_W'(N_REQ-1)) ? '0 : grant_id + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (grant) begin
      op_a <= req_a[GF_M*int'(grant_id) +: GF_M];
      op_b <= req_b[GF_M*int'(grant_id) +: GF_M];
    end
  end

  gf2m_mult163 #(.LAT(MULT_LAT)) u_mult (
    .clk (clk),
    .a   (op_a),
    .b   (op_b),
    .p   (mult_p)
  );

  // The tag pipe is one stage longer than the multiplier so its tail lines up with mult_p.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s <= MULT_LAT; s++) tag_pipe[s] <= '0;
    end else begin
      tag_pipe[0] <= '{valid: grant, id: grant_id};
      for (int s = 1; s <= MULT_LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
    end
  end

  assign retire = tag_pipe[MULT_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= '0;
      if (retire.valid) begin
        rsp_valid[retire.id] <= 1'b1;
        rsp_data             <= mult_p;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({grant, retire.valid})
        2'b10:   inflight <= inflight + 3'd1;
        2'b01:   inflight <= inflight - 3'd1;
        default: inflight <= inflight;
      endcase
    end
  end

endmodule
